// File: rtl/math_pkg.sv
// Shared types and helpers for the math-system ALU issue path.
// iq_entry_t is the scheduler slot layout; pack_issue builds the EX10 packet.
package math_pkg;
  localparam int PREG_W      = 6;
  localparam int ROB_W       = 5;
  localparam int ISSUE_PKT_W = 18;

  typedef struct packed {
    logic              valid;
    logic [ROB_W-1:0]  rob;
    logic [PREG_W-1:0] rs1;
    logic              rs1_rdy;
    logic [PREG_W-1:0] rs2;
    logic              rs2_rdy;
  } iq_entry_t;

  // EX10 layout: [4:0] rob, [5] pad, [11:6] rs1, [17:12] rs2
  function automatic logic [ISSUE_PKT_W-1:0] pack_issue(input iq_entry_t e);
    return {e.rs2, e.rs1, 1'b0, e.rob};
  endfunction
endpackage

// File: rtl/math_iq_wakeup_cmp.sv
// Compares one slot's source tags against every writeback wakeup port.
// Purely combinational; one copy per queue entry plus one for the dispatch slot.
module math_iq_wakeup_cmp
  import math_pkg::*;
#(
  parameter int WAKE_PORTS = 2
) (
  input  logic [PREG_W-1:0]            rs1_tag,
  input  logic [PREG_W-1:0]            rs2_tag,
  input  logic [WAKE_PORTS-1:0]        wakeup_valid,
  input  logic [PREG_W*WAKE_PORTS-1:0] wakeup_tag,
  output logic                         rs1_hit,
  output logic                         rs2_hit
);
  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int k = 0; k < WAKE_PORTS; k++) begin
      if (wakeup_valid[k] && wakeup_tag[k*PREG_W +: PREG_W] == rs1_tag) rs1_hit = 1'b1;
      if (wakeup_valid[k] && wakeup_tag[k*PREG_W +: PREG_W] == rs2_tag) rs2_hit = 1'b1;
    end
  end
endmodule

// File: rtl/math_issue_queue.sv
// Collapsing, age-ordered ALU issue queue: index 0 is oldest, valid slots are
// contiguous, and the oldest entry with both sources ready issues each cycle.
module math_issue_queue
  import math_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int WAKE_PORTS = 2
) (
  input  logic                         cpu_clock_i,
  input  logic                         cpu_reset_i,
  input  logic                         flush_i,
  input  logic                         dispatch_valid_i,
  output logic                         dispatch_ready_o,
  input  logic [ROB_W-1:0]             dispatch_rob_i,
  input  logic [PREG_W-1:0]            dispatch_rs1_i,
  input  logic                         dispatch_rs1_rdy_i,
  input  logic [PREG_W-1:0]            dispatch_rs2_i,
  input  logic                         dispatch_rs2_rdy_i,
  input  logic [WAKE_PORTS-1:0]        wakeup_valid_i,
  input  logic [PREG_W*WAKE_PORTS-1:0] wakeup_tag_i,
  output logic [ISSUE_PKT_W-1:0]       issue_data_o,
  output logic                         issue_valid_o,
  output logic [$clog2(DEPTH):0]       count_o
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  iq_entry_t [DEPTH-1:0] q;
  iq_entry_t [DEPTH-1:0] q_nxt;
  iq_entry_t [DEPTH:0]   woke;     // extra top slot feeds zeros into the collapse
  iq_entry_t             disp_e;
  iq_entry_t             sel_e;
  logic      [CNT_W-1:0] cnt;
  logic      [CNT_W-1:0] sel_idx;
  logic      [CNT_W-1:0] wr_idx;
  logic      [DEPTH-1:0] rs1_hit, rs2_hit, cand;
  logic                  d_rs1_hit, d_rs2_hit;
  logic                  issued, disp_fire;

  assign count_o          = cnt;
  assign dispatch_ready_o = (cnt < CNT_W'(DEPTH));
  assign disp_fire        = dispatch_valid_i & dispatch_ready_o;
  assign wr_idx           = cnt - CNT_W'(issued);

  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    math_iq_wakeup_cmp #(.WAKE_PORTS(WAKE_PORTS)) u_cmp (
      .rs1_tag      (q[g].rs1),
      .rs2_tag      (q[g].rs2),
      .wakeup_valid (wakeup_valid_i),
      .wakeup_tag   (wakeup_tag_i),
      .rs1_hit      (rs1_hit[g]),
      .rs2_hit      (rs2_hit[g])
    );
    assign cand[g] = q[g].valid & q[g].rs1_rdy & q[g].rs2_rdy;
  end

  math_iq_wakeup_cmp #(.WAKE_PORTS(WAKE_PORTS)) u_cmp_disp (
    .rs1_tag      (dispatch_rs1_i),
    .rs2_tag      (dispatch_rs2_i),
    .wakeup_valid (wakeup_valid_i),
    .wakeup_tag   (wakeup_tag_i),
    .rs1_hit      (d_rs1_hit),
    .rs2_hit      (d_rs2_hit)
  );

  always_comb begin
    disp_e         = '0;
    disp_e.valid   = 1'b1;
    disp_e.rob     = dispatch_rob_i;
    disp_e.rs1     = dispatch_rs1_i;
    disp_e.rs1_rdy = dispatch_rs1_rdy_i | d_rs1_hit;
    disp_e.rs2     = dispatch_rs2_i;
    disp_e.rs2_rdy = dispatch_rs2_rdy_i | d_rs2_hit;
  end

  // Ready bits set here only become visible to select after the edge.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = q[i];
      if (q[i].valid) begin
        woke[i].rs1_rdy = q[i].rs1_rdy | rs1_hit[i];
        woke[i].rs2_rdy = q[i].rs2_rdy | rs2_hit[i];
      end
    end
    woke[DEPTH] = '0;
  end

  // Descending scan so the lowest-index (oldest) candidate wins.
  always_comb begin
    issued  = 1'b0;
    sel_idx = '0;
    sel_e   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        issued  = 1'b1;
        sel_idx = CNT_W'(i);
        sel_e   = q[i];
      end
    end
  end

  // Collapse above the issued slot, then append at the post-collapse tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (issued && CNT_W'(i) >= sel_idx) q_nxt[i] = woke[i+1];
      else                                q_nxt[i] = woke[i];
      if (disp_fire && CNT_W'(i) == wr_idx) q_nxt[i] = disp_e;
    end
  end

  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      q             <= '0;
      cnt           <= '0;
      issue_valid_o <= 1'b0;
      issue_data_o  <= '0;
    end else if (flush_i) begin
      q             <= '0;
      cnt           <= '0;
      issue_valid_o <= 1'b0;
    end else begin
      q             <= q_nxt;
      cnt           <= cnt + CNT_W'(disp_fire) - CNT_W'(issued);
      issue_valid_o <= issued;
      if (issued) issue_data_o <= pack_issue(sel_e);
    end
  end

  logic [CNT_W-1:0] pop;
  logic             contig_ok;
  always_comb begin
    pop       = '0;
    contig_ok = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      pop = pop + CNT_W'(q[i].valid);
      if (i > 0 && q[i].valid && !q[i-1].valid) contig_ok = 1'b0;
    end
  end

  a_cnt_max: assert property (@(posedge cpu_clock_i) disable iff (cpu_reset_i)
                              cnt <= CNT_W'(DEPTH));
  a_contig:  assert property (@(posedge cpu_clock_i) disable iff (cpu_reset_i) contig_ok);
  a_pop:     assert property (@(posedge cpu_clock_i) disable iff (cpu_reset_i) pop == cnt);
endmodule

// File: tb/tb_math_issue_queue.sv
// Directed bench for math_issue_queue: dispatch/issue latency, wakeup, age
// order, full-with-issue, same-cycle wakeup, flush and async reset.
module tb_math_issue_queue;
  import math_pkg::*;

  localparam int DEPTH = 8;
  localparam int WP    = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic                 dv;
  logic                 drdy;
  logic [ROB_W-1:0]     drob;
  logic [PREG_W-1:0]    drs1, drs2;
  logic                 drs1_rdy, drs2_rdy;
  logic [WP-1:0]        wv;
  logic [PREG_W*WP-1:0] wt;
  logic [ISSUE_PKT_W-1:0] idata;
  logic                 ivalid;
  logic [$clog2(DEPTH):0] cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  math_issue_queue #(.DEPTH(DEPTH), .WAKE_PORTS(WP)) dut (
    .cpu_clock_i        (clk),
    .cpu_reset_i        (rst),
    .flush_i            (flush),
    .dispatch_valid_i   (dv),
    .dispatch_ready_o   (drdy),
    .dispatch_rob_i     (drob),
    .dispatch_rs1_i     (drs1),
    .dispatch_rs1_rdy_i (drs1_rdy),
    .dispatch_rs2_i     (drs2),
    .dispatch_rs2_rdy_i (drs2_rdy),
    .wakeup_valid_i     (wv),
    .wakeup_tag_i       (wt),
    .issue_data_o       (idata),
    .issue_valid_o      (ivalid),
    .count_o            (cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pkt(input int rob, input int rs1, input int rs2);
    logic [ISSUE_PKT_W-1:0] p;
    p = {PREG_W'(rs2), PREG_W'(rs1), 1'b0, ROB_W'(rob)};
    return 32'(p);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input int rob, input int rs1, input logic r1, input int rs2, input logic r2);
    dv = 1'b1; drob = ROB_W'(rob);
    drs1 = PREG_W'(rs1); drs1_rdy = r1;
    drs2 = PREG_W'(rs2); drs2_rdy = r2;
  endtask

  task automatic idle();
    dv = 1'b0; wv = '0; wt = '0; flush = 1'b0;
  endtask

  task automatic wake(input int port, input int tag);
    wv[port] = 1'b1;
    wt[port*PREG_W +: PREG_W] = PREG_W'(tag);
  endtask

  // Issue state and count after an edge
  task automatic chk_state(input string tag, input logic v, input int c);
    chk({tag, ".ivalid"}, 32'(ivalid), 32'(v));
    chk({tag, ".count"},  32'(cnt),    32'(c));
  endtask

  initial begin
    rst = 1'b1; idle();
    drob = '0; drs1 = '0; drs2 = '0; drs1_rdy = 1'b0; drs2_rdy = 1'b0;
    #2;
    chk("rst.count", 32'(cnt), 0);
    chk("rst.ivalid", 32'(ivalid), 0);
    chk("rst.idata", 32'(idata), 0);
    step(); step();
    rst = 1'b0;
    step();
    chk("rst.ready", 32'(drdy), 1);

    // 1: ready dispatch issues the following cycle
    disp(3, 10, 1, 11, 1); step();
    chk_state("t1.disp", 0, 1);
    idle(); step();
    chk_state("t1.iss", 1, 0);
    chk("t1.data", 32'(idata), pkt(3, 10, 11));
    step();
    chk_state("t1.quiet", 0, 0);
    chk("t1.hold", 32'(idata), pkt(3, 10, 11));

    // 2: younger ready op bypasses waiting op; wakeup has no same-cycle issue
    disp(1, 20, 0, 21, 1); step();
    disp(2, 22, 1, 23, 1); step();
    chk_state("t2.fill", 0, 2);
    idle(); step();
    chk_state("t2.iss2", 1, 1);
    chk("t2.data2", 32'(idata), pkt(2, 22, 23));
    step();
    chk_state("t2.wait", 0, 1);
    wake(1, 20); step();
    chk_state("t2.wake_edge", 0, 1);
    idle(); step();
    chk_state("t2.iss1", 1, 0);
    chk("t2.data1", 32'(idata), pkt(1, 20, 21));

    // 3: age order after a single broadcast, ready tracks full
    for (int i = 0; i < 8; i++) begin disp(i, 30 + i, 1, 5, 0); step(); end
    idle();
    chk_state("t3.full", 0, 8);
    chk("t3.ready_full", 32'(drdy), 0);
    wake(0, 5); step();
    chk_state("t3.wake", 0, 8);
    idle();
    for (int k = 0; k < 8; k++) begin
      step();
      chk_state($sformatf("t3.iss%0d", k), 1, 7 - k);
      chk($sformatf("t3.data%0d", k), 32'(idata), pkt(k, 30 + k, 5));
      chk($sformatf("t3.ready%0d", k), 32'(drdy), 1);
    end
    step();
    chk_state("t3.empty", 0, 0);

    // 4: full queue refuses dispatch even while the head issues
    disp(0, 40, 1, 7, 0); step();
    for (int i = 1; i < 8; i++) begin disp(i, 40 + i, 1, 5, 0); step(); end
    idle(); wake(0, 7); step();
    chk_state("t4.wake", 0, 8);
    idle(); disp(9, 50, 1, 51, 1); step();
    chk_state("t4.iss", 1, 7);
    chk("t4.data", 32'(idata), pkt(0, 40, 7));
    idle(); step();
    chk_state("t4.refused", 0, 7);
    flush = 1'b1; step();
    idle();
    chk_state("t4.flush", 0, 0);

    // 5: wakeup matching the op being dispatched
    disp(4, 33, 0, 34, 1); wake(0, 33); step();
    chk_state("t5.disp", 0, 1);
    idle(); step();
    chk_state("t5.iss", 1, 0);
    chk("t5.data", 32'(idata), pkt(4, 33, 34));

    // 6a: flush beats candidate and dispatch
    for (int i = 0; i < 5; i++) begin disp(10 + i, 60 + i, 1, 5, 0); step(); end
    idle(); wake(1, 5); step();
    chk_state("t6.wake", 0, 5);
    idle(); flush = 1'b1; disp(20, 1, 1, 2, 1); step();
    idle();
    chk_state("t6.flush", 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_state($sformatf("t6.after%0d", k), 0, 0);
    end

    // 6b: async reset mid-cycle clears outputs without an edge
    for (int i = 0; i < 5; i++) begin disp(10 + i, 60 + i, 1, 5, 0); step(); end
    idle(); wake(1, 5); step();
    idle(); step();
    chk_state("t6r.iss", 1, 4);
    chk("t6r.data", 32'(idata), pkt(10, 60, 5));
    #2 rst = 1'b1;
    #1;
    chk_state("t6r.async", 0, 0);
    chk("t6r.idata", 32'(idata), 0);
    #2 rst = 1'b0;
    step();
    chk_state("t6r.post", 0, 0);
    step();
    chk_state("t6r.post2", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end
endmodule

// File: doc/math_issue_queue.md
Name: math_issue_queue

Overview:
- Collapsing, age-ordered issue queue (scheduler) for the math-system ALU.
- Accepts renamed ALU micro-ops from dispatch and holds them until both source physical registers are ready. Ready state comes from writeback wakeup broadcasts.
- Each cycle it issues the oldest ready entry to the EX10 operand-read stage through the 18-bit {rs2,rs1,pad,rob} packet and a valid strobe.
- Sits between the rename/dispatch logic and EX10.

Parameters:
- DEPTH, 8, number of queue entries (power of two, 2..16).
- WAKE_PORTS, 2, number of writeback wakeup broadcast ports.

Ports:
- cpu_clock_i  input  1  sole clock, rising edge.
- cpu_reset_i  input  1  asynchronous, active-high reset.
- flush_i  input  1  pipeline flush; synchronous clear of all entries.
- dispatch_valid_i  input  1  dispatch offers one micro-op.
- dispatch_ready_o  output  1  queue can accept this cycle.
- dispatch_rob_i  input  5  ROB id.
- dispatch_rs1_i  input  6  source 1 physical tag.
- dispatch_rs1_rdy_i  input  1  source 1 already available.
- dispatch_rs2_i  input  6  source 2 physical tag.
- dispatch_rs2_rdy_i  input  1  source 2 available (dispatch drives 1 for immediate ops).
- wakeup_valid_i  input  WAKE_PORTS  per-port broadcast valid.
- wakeup_tag_i  input  6*WAKE_PORTS  per-port physical tag; port k occupies bits [6k+5:6k].
- issue_data_o  output  18  [4:0] rob, [5] 0, [11:6] rs1, [17:12] rs2.
- issue_valid_o  output  1  issue_data_o valid this cycle.
- count_o  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
Entry storage
- Each entry holds: valid, rob, rs1, rs1_rdy, rs2, rs2_rdy.
- Entries are kept compacted: index 0 is the oldest; valid entries are contiguous from index 0.

Reset
- cpu_reset_i asserted (asynchronous): all entry valid bits 0, count_o=0, issue_valid_o=0, issue_data_o=0.
- After reset deasserts, dispatch_ready_o=1.
- Reset mid-operation discards all entries without issuing.

Dispatch
- dispatch_ready_o = (count_o < DEPTH). It is purely registered state, with no combinational dependence on issue or dispatch inputs.
- A transfer occurs when dispatch_valid_i & dispatch_ready_o.
- The new entry is written at index count minus the number of entries issued this cycle (0 or 1).
- When full, dispatch is refused even if an issue occurs in the same cycle.

Wakeup
- Each valid wakeup port compares its tag against every valid entry's rs1/rs2. On a match, the corresponding rdy bit is set at the clock edge.
- Wakeup also applies to the entry being dispatched in the same cycle: its rdy bit = dispatch_rdy_i | any match.
- A set ready bit is visible to select the following cycle. There is no same-cycle wakeup-to-issue bypass.

Select and issue
- Candidate = valid & rs1_rdy & rs2_rdy, evaluated from registered entry state.
- The lowest-index candidate is chosen.
- At the edge: issue_data_o <= packed fields of the chosen entry, issue_valid_o <= 1. The entry is removed, and entries above it shift down by one, preserving age order.
- With no candidate: issue_valid_o <= 0, and issue_data_o holds its value.
- Latency: an entry dispatched ready issues at the earliest on the edge after the dispatch edge (issue_valid_o high in cycle N+1 for dispatch in cycle N), provided it is the oldest ready entry.
- No backpressure: EX10 accepts one packet per cycle unconditionally.

Simultaneous events
- Issue, dispatch and wakeup can all occur in one cycle. Shift, append and rdy-set combine on the same edge.
- count_o next = count + dispatched − issued.

Flush
- flush_i has priority over dispatch, issue and wakeup: all valid bits clear, count_o <= 0, issue_valid_o <= 0 next cycle.
- A dispatch offered in the flush cycle is dropped.

Invariants (assertions)
- count_o ≤ DEPTH.
- Valid bits are contiguous from index 0.
- count_o equals the popcount of the valid bits.

Decomposition:
- Shared package math_pkg holds:
  - typedef iq_entry_t {valid, rob[4:0], rs1[5:0], rs1_rdy, rs2[5:0], rs2_rdy};
  - constants PREG_W=6, ROB_W=5, ISSUE_PKT_W=18;
  - function pack_issue(entry) producing the EX10 packet layout.
- One sub-module: math_iq_wakeup_cmp. It is purely combinational: one entry's tags against all WAKE_PORTS, returning {rs1_hit, rs2_hit}. It is instantiated per entry plus once for the dispatch slot.
- Priority select and collapse shift stay in the top module.

Test Plan:
1. Reset, then dispatch rob=3, rs1=10 rdy, rs2=11 rdy in cycle 0 -> cycle 1 issue_valid_o=1, issue_data_o={6'd11,6'd10,1'b0,5'd3}; count_o returns to 0.
2. Dependency wakeup:
   - Dispatch rob=1 with rs1=20 not ready, then rob=2 fully ready.
   - Expected: rob=2 issues first.
   - Then wakeup tag 20 on port 1: rob=1 issues the cycle after the wakeup edge, never the same cycle.
3. Age order: fill 8 entries (rob 0..7), all rs2=5 not ready; broadcast tag 5 once -> rob 0..7 issue in order on 8 consecutive cycles. dispatch_ready_o=0 while count_o=8, 1 again after the first issue.
4. Full with simultaneous issue: count_o=8 with a ready head, dispatch_valid_i=1 -> dispatch refused, head issues, count_o=7.
5. Same-cycle dispatch+wakeup: dispatch rs1=33 not ready while wakeup_tag port0=33 -> entry issues the next cycle.
6. Flush and reset:
   - Flush with 5 entries and a candidate present, plus dispatch_valid_i=1 -> next cycle issue_valid_o=0, count_o=0, no later issue of the old entries.
   - Repeat with async cpu_reset_i pulsed mid-cycle -> outputs clear immediately, without waiting for a clock edge.
